mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single main-memory bus between the instruction cache (loads only) and the data cache (loads and stores).
- Each cycle it forwards at most one request to memory. It returns the memory's accept/reject response to the granted requester.
- It tracks each outstanding load tag with its owner, so that data returning later is routed to the correct cache.
- It sits between the fetch/LSQ cache controllers and the proc2mem/mem2proc port of the core.

Parameters:
- NUM_TAGS, 15: number of valid memory tags; tag 0 means none/rejected.
- IC_MAX_WAIT, 4: maximum number of consecutive cycles the icache can lose arbitration before it is forced a grant.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ic2arb_req_i  input  1  icache load request
- ic2arb_addr_i  input  64  icache load address
- dc2arb_command_i  input  2  dcache command: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2
- dc2arb_addr_i  input  64  dcache address
- dc2arb_data_i  input  64  dcache store data
- arb2ic_response_o  output  4  memory response tag to icache; 0 = not accepted
- arb2dc_response_o  output  4  memory response tag to dcache; 0 = not accepted
- arb2ic_tag_o  output  4  returning tag routed to icache; 0 = none
- arb2ic_data_o  output  64  returning data for icache
- arb2dc_tag_o  output  4  returning tag routed to dcache; 0 = none
- arb2dc_data_o  output  64  returning data for dcache
- proc2mem_command_o  output  2  command to memory
- proc2mem_addr_o  output  64  address to memory
- proc2mem_data_o  output  64  store data to memory
- mem2proc_response_i  input  4  same-cycle accept tag from memory
- mem2proc_tag_i  input  4  tag of returning load data; 0 = none
- mem2proc_data_i  input  64  returning load data
- arb_grant_dc_o  output  1  1 = dcache holds the bus this cycle (debug/perf)
- arb_tag_err_o  output  1  sticky error flag

Behaviour:
- Grant is combinational within the cycle, because memory answers in the same cycle.
  - Only icache requesting: icache is granted.
  - Only dcache requesting (command != 0): dcache is granted.
  - Both requesting: dcache wins unless wait_cnt == IC_MAX_WAIT, in which case icache wins.
  - Neither requesting: proc2mem_command_o = BUS_NONE; addr and data are 0.
- Mux: the granted requester's command, addr and data drive proc2mem_*. For an icache grant, command = BUS_LOAD and data = 0.
- Response: the granted requester receives mem2proc_response_i. The non-granted requester sees 0 and must hold its request and retry.
- wait_cnt register, 3 bits for the default parameter:
  - increments (saturating at IC_MAX_WAIT) when ic2arb_req_i=1 and the icache is not granted;
  - clears to 0 when the icache is granted or ic2arb_req_i=0.
- Owner table: vld[1..NUM_TAGS] and own_dc[1..NUM_TAGS], updated at posedge clk.
  - Allocate: a granted BUS_LOAD with mem2proc_response_i != 0 sets vld[resp]=1 and own_dc[resp]=(dcache granted).
  - Stores are never allocated; they have no data return.
  - Allocating a tag whose vld is already 1: the entry is overwritten and arb_tag_err_o is set.
- Return routing is combinational. When mem2proc_tag_i = t != 0 and vld[t] = 1:
  - the owner receives tag t and mem2proc_data_i;
  - the other cache receives tag 0 and data 0;
  - vld[t] clears at the next edge.
- Unknown return: mem2proc_tag_i != 0 with vld = 0 → routed to neither cache, and arb_tag_err_o is set.
- Same tag returning and re-allocated in the same cycle: the return is routed first; the allocation wins the table update, so vld stays 1 with the new owner.
- arb_tag_err_o is sticky; only rst clears it.
- Reset (synchronous, including mid-transaction):
  - vld, own_dc, wait_cnt and arb_tag_err_o clear to 0.
  - While rst=1, proc2mem_command_o = BUS_NONE, both response outputs are 0, both return tags are 0, and arb_grant_dc_o = 0.
  - Outstanding loads are forgotten; their later returns count as unknown returns.
- Both requesters may have loads in flight simultaneously. Up to NUM_TAGS outstanding loads in total.

Test Plan:
- Icache-only load at 0x100, memory responds 3, tag 3 returns 10 cycles later with 0xDEAD → arb2ic_response_o=3; later arb2ic_tag_o=3, arb2ic_data_o=0xDEAD, arb2dc_tag_o=0.
- Both requesting for 6 cycles, memory accepts every request → dcache granted cycles 0-3, icache granted cycle 4 (wait_cnt=4), dcache cycle 5; arb2ic_response_o=0 on denied cycles.
- Dcache store at 0x200 with data 0x55, response 5 → proc2mem_command_o=2, data 0x55; vld[5] stays 0; a later mem2proc_tag_i=5 sets arb_tag_err_o=1.
- Icache load on tag 2 and dcache load on tag 7 outstanding; 7 returns before 2 → each cache gets only its own tag and data, out of order.
- Tag 4 returns in the same cycle the dcache load is allocated tag 4 → icache gets the return; next cycle vld[4]=1, own_dc[4]=1, no error.
- rst asserted with 3 loads outstanding → the table clears, proc2mem_command_o=0 during reset, and a stale return after reset sets arb_tag_err_o.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single main-memory bus between the instruction cache (loads
//   only) and the data cache (loads and stores). At most one request per
//   cycle is forwarded to memory, and the same-cycle accept tag goes back to
//   the granted requester. Each accepted load tag is recorded with its owner
//   so that data returning later is routed to the cache that asked for it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ic2arb_req_i/addr_i       icache load request
//   dc2arb_command_i/addr_i/data_i  dcache command (0 none, 1 load, 2 store)
//   arb2ic_response_o         accept tag to icache (0 = not accepted)
//   arb2dc_response_o         accept tag to dcache (0 = not accepted)
//   arb2ic_tag_o/data_o       returning load data routed to icache
//   arb2dc_tag_o/data_o       returning load data routed to dcache
//   proc2mem_command_o/addr_o/data_o  request driven to memory
//   mem2proc_response_i       same-cycle accept tag from memory
//   mem2proc_tag_i/data_i     returning load tag and data (tag 0 = none)
//   arb_grant_dc_o            dcache holds the bus this cycle
//   arb_tag_err_o             sticky flag: tag reused while live, or unknown return
module mem_bus_arbiter #(
  parameter int unsigned NUM_TAGS    = 15,
  parameter int unsigned IC_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic2arb_req_i,
  input  logic [63:0] ic2arb_addr_i,
  input  logic [1:0]  dc2arb_command_i,
  input  logic [63:0] dc2arb_addr_i,
  input  logic [63:0] dc2arb_data_i,
  output logic [3:0]  arb2ic_response_o,
  output logic [3:0]  arb2dc_response_o,
  output logic [3:0]  arb2ic_tag_o,
  output logic [63:0] arb2ic_data_o,
  output logic [3:0]  arb2dc_tag_o,
  output logic [63:0] arb2dc_data_o,
  output logic [1:0]  proc2mem_command_o,
  output logic [63:0] proc2mem_addr_o,
  output logic [63:0] proc2mem_data_o,
  input  logic [3:0]  mem2proc_response_i,
  input  logic [3:0]  mem2proc_tag_i,
  input  logic [63:0] mem2proc_data_i,
  output logic        arb_grant_dc_o,
  output logic        arb_tag_err_o
);

  localparam int unsigned WW = $clog2(IC_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(IC_MAX_WAIT);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  // Entry 0 is never allocated; it stands for "no tag".
  logic [NUM_TAGS:0] r_vld;
  logic [NUM_TAGS:0] r_own_dc;
  logic [WW-1:0]     r_wait_cnt;
  logic              r_tag_err;

  logic w_ic_req;
  logic w_dc_req;
  logic w_grant_ic;
  logic w_grant_dc;
  logic w_ret_hit;
  logic w_ret_unknown;
  logic w_alloc;
  logic w_alloc_clash;
  logic w_resp_in_range;
  logic w_ret_in_range;

  assign w_ic_req = ic2arb_req_i;
  assign w_dc_req = (dc2arb_command_i != BUS_NONE);

  // dcache has priority unless the icache has been starved IC_MAX_WAIT cycles.
  assign w_grant_dc = !rst && w_dc_req && (!w_ic_req || (r_wait_cnt != WAIT_MAX));
  assign w_grant_ic = !rst && w_ic_req && (!w_dc_req || (r_wait_cnt == WAIT_MAX));

  assign w_resp_in_range = (32'(mem2proc_response_i) <= NUM_TAGS);
  assign w_ret_in_range  = (32'(mem2proc_tag_i) <= NUM_TAGS);

  assign w_ret_hit     = !rst && (mem2proc_tag_i != '0) && w_ret_in_range
                         && r_vld[mem2proc_tag_i];
  assign w_ret_unknown = (mem2proc_tag_i != '0) && !w_ret_hit;

  assign w_alloc = (w_grant_ic || (w_grant_dc && dc2arb_command_i == BUS_LOAD))
                   && (mem2proc_response_i != '0) && w_resp_in_range;

  // A tag that returns this cycle is free for re-allocation in the same cycle.
  assign w_alloc_clash = w_alloc && r_vld[mem2proc_response_i]
                         && !(w_ret_hit && mem2proc_tag_i == mem2proc_response_i);

  always_comb begin
    proc2mem_command_o = BUS_NONE;
    proc2mem_addr_o    = '0;
    proc2mem_data_o    = '0;
    arb2ic_response_o  = '0;
    arb2dc_response_o  = '0;
    arb2ic_tag_o       = '0;
    arb2ic_data_o      = '0;
    arb2dc_tag_o       = '0;
    arb2dc_data_o      = '0;
    if (w_grant_dc) begin
      proc2mem_command_o = dc2arb_command_i;
      proc2mem_addr_o    = dc2arb_addr_i;
      proc2mem_data_o    = dc2arb_data_i;
      arb2dc_response_o  = mem2proc_response_i;
    end else if (w_grant_ic) begin
      proc2mem_command_o = BUS_LOAD;
      proc2mem_addr_o    = ic2arb_addr_i;
      arb2ic_response_o  = mem2proc_response_i;
    end
    if (w_ret_hit) begin
      if (r_own_dc[mem2proc_tag_i]) begin
        arb2dc_tag_o  = mem2proc_tag_i;
        arb2dc_data_o = mem2proc_data_i;
      end else begin
        arb2ic_tag_o  = mem2proc_tag_i;
        arb2ic_data_o = mem2proc_data_i;
      end
    end
  end

  assign arb_grant_dc_o = w_grant_dc;
  assign arb_tag_err_o  = r_tag_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld      <= '0;
      r_own_dc   <= '0;
      r_wait_cnt <= '0;
      r_tag_err  <= 1'b0;
    end else begin
      if (w_ic_req && !w_grant_ic)
        r_wait_cnt <= (r_wait_cnt == WAIT_MAX) ? WAIT_MAX : r_wait_cnt + 1'b1;
      else
        r_wait_cnt <= '0;

      if (w_ret_hit)
        r_vld[mem2proc_tag_i] <= 1'b0;
      // Allocation is written after the return clear so it wins on the same tag.
      if (w_alloc) begin
        r_vld[mem2proc_response_i]    <= 1'b1;
        r_own_dc[mem2proc_response_i] <= w_grant_dc;
      end

      if (w_ret_unknown || w_alloc_clash)
        r_tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  localparam int NT   = 15;
  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic2arb_req_i = 1'b0;
  logic [63:0] ic2arb_addr_i = '0;
  logic [1:0]  dc2arb_command_i = '0;
  logic [63:0] dc2arb_addr_i = '0;
  logic [63:0] dc2arb_data_i = '0;
  logic [3:0]  arb2ic_response_o, arb2dc_response_o;
  logic [3:0]  arb2ic_tag_o, arb2dc_tag_o;
  logic [63:0] arb2ic_data_o, arb2dc_data_o;
  logic [1:0]  proc2mem_command_o;
  logic [63:0] proc2mem_addr_o, proc2mem_data_o;
  logic [3:0]  mem2proc_response_i = '0;
  logic [3:0]  mem2proc_tag_i = '0;
  logic [63:0] mem2proc_data_i = '0;
  logic        arb_grant_dc_o, arb_tag_err_o;

  mem_bus_arbiter #(.NUM_TAGS(NT), .IC_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .ic2arb_req_i(ic2arb_req_i), .ic2arb_addr_i(ic2arb_addr_i),
    .dc2arb_command_i(dc2arb_command_i), .dc2arb_addr_i(dc2arb_addr_i),
    .dc2arb_data_i(dc2arb_data_i),
    .arb2ic_response_o(arb2ic_response_o), .arb2dc_response_o(arb2dc_response_o),
    .arb2ic_tag_o(arb2ic_tag_o), .arb2ic_data_o(arb2ic_data_o),
    .arb2dc_tag_o(arb2dc_tag_o), .arb2dc_data_o(arb2dc_data_o),
    .proc2mem_command_o(proc2mem_command_o), .proc2mem_addr_o(proc2mem_addr_o),
    .proc2mem_data_o(proc2mem_data_o),
    .mem2proc_response_i(mem2proc_response_i), .mem2proc_tag_i(mem2proc_tag_i),
    .mem2proc_data_i(mem2proc_data_i),
    .arb_grant_dc_o(arb_grant_dc_o), .arb_tag_err_o(arb_tag_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr, data;
    logic [3:0]  icr, dcr, ict, dct;
    logic [63:0] icd, dcd;
    logic        gdc, err;
    bit          chk_bus, chk_err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: who owns each tag (0 free, 1 icache, 2 dcache),
  // how many cycles in a row the icache has lost, and the error flag.
  int m_owner[1:NT];
  int m_lost = 0;
  bit m_err = 1'b0;
  bit m_err_known = 1'b0;

  // 0 = nobody, 1 = icache, 2 = dcache
  function automatic int pred_grant(bit icr, logic [1:0] dcc);
    bit dcw = (dcc != 2'd0);
    if (icr && dcw) return (m_lost >= MAXW) ? 1 : 2;
    if (icr) return 1;
    if (dcw) return 2;
    return 0;
  endfunction

  task automatic drive(input bit r, input bit icr, input logic [63:0] ica,
                       input logic [1:0] dcc, input logic [63:0] dca, input logic [63:0] dcd,
                       input logic [3:0] resp, input logic [3:0] rt, input logic [63:0] rd);
    exp_t e;
    int g;
    @(posedge clk);
    #1;
    rst = r; ic2arb_req_i = icr; ic2arb_addr_i = ica;
    dc2arb_command_i = dcc; dc2arb_addr_i = dca; dc2arb_data_i = dcd;
    mem2proc_response_i = resp; mem2proc_tag_i = rt; mem2proc_data_i = rd;
    e.cmd = '0; e.addr = '0; e.data = '0; e.icr = '0; e.dcr = '0;
    e.ict = '0; e.dct = '0; e.icd = '0; e.dcd = '0; e.gdc = 1'b0;
    e.err = m_err; e.chk_err = m_err_known; e.chk_bus = !r;
    if (r) begin
      for (int t = 1; t <= NT; t++) m_owner[t] = 0;
      m_lost = 0; m_err = 1'b0; m_err_known = 1'b1;
    end else begin
      g = pred_grant(icr, dcc);
      if (g == 2) begin
        e.cmd = dcc; e.addr = dca; e.data = dcd; e.dcr = resp; e.gdc = 1'b1;
      end else if (g == 1) begin
        e.cmd = 2'd1; e.addr = ica; e.icr = resp;
      end
      if (rt != 0) begin
        if (m_owner[int'(rt)] == 1) begin e.ict = rt; e.icd = rd; end
        else if (m_owner[int'(rt)] == 2) begin e.dct = rt; e.dcd = rd; end
        else m_err = 1'b1;
        m_owner[int'(rt)] = 0;
      end
      if ((g == 1 || (g == 2 && dcc == 2'd1)) && resp != 0) begin
        if (m_owner[int'(resp)] != 0) m_err = 1'b1;
        m_owner[int'(resp)] = g;
      end
      if (icr && g != 1) m_lost = (m_lost + 1 > MAXW) ? MAXW : m_lost + 1;
      else m_lost = 0;
    end
    q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] rt, input logic [63:0] rd);
    drive(1'b0, 1'b0, '0, 2'd0, '0, '0, 4'd0, rt, rd);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 2'd0, '0, '0, 4'd0, 4'd0, '0);
    drive(1'b1, 1'b0, '0, 2'd0, '0, '0, 4'd0, 4'd0, '0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are presented every cycle, so one expectation is popped per cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("cmd", 64'(proc2mem_command_o), 64'(e.cmd));
      chk("ic_resp", 64'(arb2ic_response_o), 64'(e.icr));
      chk("dc_resp", 64'(arb2dc_response_o), 64'(e.dcr));
      chk("ic_tag", 64'(arb2ic_tag_o), 64'(e.ict));
      chk("dc_tag", 64'(arb2dc_tag_o), 64'(e.dct));
      chk("grant_dc", 64'(arb_grant_dc_o), 64'(e.gdc));
      if (e.chk_bus) begin
        chk("addr", proc2mem_addr_o, e.addr);
        chk("wdata", proc2mem_data_o, e.data);
        chk("ic_data", arb2ic_data_o, e.icd);
        chk("dc_data", arb2dc_data_o, e.dcd);
      end
      if (e.chk_err) chk("tag_err", 64'(arb_tag_err_o), 64'(e.err));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tq[$];
    int g;
    bit icr, r;
    logic [1:0] dcc;
    logic [3:0] resp, rt;
    for (int t = 1; t <= NT; t++) m_owner[t] = 0;

    // Icache-only load, data returns ten cycles later.
    do_reset();
    drive(1'b0, 1'b1, 64'h100, 2'd0, '0, '0, 4'd3, 4'd0, '0);
    for (int i = 0; i < 9; i++) idle(4'd0, '0);
    idle(4'd3, 64'hDEAD);

    // Both requesting six cycles: icache forced on the fifth.
    do_reset();
    for (int i = 0; i < 6; i++)
      drive(1'b0, 1'b1, 64'h300 + 64'(i), 2'd1, 64'h400 + 64'(i), '0, 4'(8 + i), 4'd0, '0);

    // Store is not allocated; its tag returning later is an error.
    do_reset();
    drive(1'b0, 1'b0, '0, 2'd2, 64'h200, 64'h55, 4'd5, 4'd0, '0);
    idle(4'd0, '0);
    idle(4'd5, 64'h1234);
    idle(4'd0, '0);

    // Out-of-order returns to different owners.
    do_reset();
    drive(1'b0, 1'b1, 64'h500, 2'd0, '0, '0, 4'd2, 4'd0, '0);
    drive(1'b0, 1'b0, '0, 2'd1, 64'h600, '0, 4'd7, 4'd0, '0);
    idle(4'd7, 64'hD7D7);
    idle(4'd2, 64'h1C1C);

    // Same tag returns and is re-allocated in one cycle.
    do_reset();
    drive(1'b0, 1'b1, 64'h700, 2'd0, '0, '0, 4'd4, 4'd0, '0);
    drive(1'b0, 1'b0, '0, 2'd1, 64'h800, '0, 4'd4, 4'd4, 64'hAAAA);
    idle(4'd4, 64'hBBBB);
    idle(4'd0, '0);

    // Reset with loads outstanding; stale return afterwards.
    do_reset();
    drive(1'b0, 1'b1, 64'h900, 2'd0, '0, '0, 4'd1, 4'd0, '0);
    drive(1'b0, 1'b0, '0, 2'd1, 64'hA00, '0, 4'd2, 4'd0, '0);
    drive(1'b0, 1'b1, 64'hB00, 2'd0, '0, '0, 4'd3, 4'd0, '0);
    drive(1'b1, 1'b1, 64'hC00, 2'd1, 64'hD00, '0, 4'd6, 4'd0, '0);
    drive(1'b1, 1'b0, '0, 2'd0, '0, '0, 4'd0, 4'd0, '0);
    idle(4'd2, 64'h5555);
    idle(4'd0, '0);

    // Randomized traffic with a tag-aware memory model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      icr = ($urandom_range(0, 2) != 0);
      dcc = 2'($urandom_range(0, 2));
      rt  = '0;
      if ($urandom_range(0, 2) == 0) begin
        tq.delete();
        for (int t = 1; t <= NT; t++) if (m_owner[t] != 0) tq.push_back(t);
        if (tq.size() > 0) rt = 4'(tq[$urandom_range(0, tq.size() - 1)]);
      end
      resp = '0;
      g = pred_grant(icr, dcc);
      if (g == 2 && dcc == 2'd2) resp = 4'($urandom_range(0, NT));
      else if (g != 0 && $urandom_range(0, 3) != 0) begin
        tq.delete();
        for (int t = 1; t <= NT; t++)
          if (m_owner[t] == 0 || t == int'(rt)) tq.push_back(t);
        if (tq.size() > 0) resp = 4'(tq[$urandom_range(0, tq.size() - 1)]);
      end
      drive(r, icr, {$urandom, $urandom}, dcc, {$urandom, $urandom},
            {$urandom, $urandom}, resp, rt, {$urandom, $urandom});
    end
    idle(4'd0, '0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
